// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel array control pins: one accepted START runs a
// complete erase / expose / convert / read frame and then pulses FRAME_DONE.
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES = 4,
  parameter int RAMP_STEPS   = 255,
  parameter int READ_CYCLES  = 2,
  parameter int EXP_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [EXP_W-1:0] EXP_TIME,
  output logic             ERASE,
  output logic             EXPOSE,
  output logic             CONVERT,
  output logic             RAMP,
  output logic             READ,
  output logic             ARRAY_RESET,
  output logic             BUSY,
  output logic             FRAME_DONE
);

  localparam int CONV_CYCLES = 2 * RAMP_STEPS + 1;
  localparam int EXP_MAX     = (1 << EXP_W) - 1;
  localparam int MAX_A       = (ERASE_CYCLES > EXP_MAX) ? ERASE_CYCLES : EXP_MAX;
  localparam int MAX_B       = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
  localparam int CNT_MAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [EXP_W-1:0] exp_last;

  // Exposure is stored as its last counter value; a request of 0 behaves as 1.
  always_ff @(posedge CLK) begin
    if (RESET_N && state == S_IDLE && START) begin
      exp_last <= (EXP_TIME == '0) ? '0 : EXP_TIME - EXP_W'(1);
    end
  end

  // Outputs are registered alongside the state, so each one already reflects
  // the phase being entered on the edge that enters it.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ERASE       <= 1'b0;
      EXPOSE      <= 1'b0;
      CONVERT     <= 1'b0;
      RAMP        <= 1'b0;
      READ        <= 1'b0;
      ARRAY_RESET <= 1'b1;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      ARRAY_RESET <= 1'b0;
      FRAME_DONE  <= 1'b0;
      RAMP        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state       <= S_ERASE;
            cnt         <= '0;
            ERASE       <= 1'b1;
            ARRAY_RESET <= 1'b1;
            BUSY        <= 1'b1;
          end
        end
        S_ERASE: begin
          if (cnt == ERASE_LAST) begin
            state  <= S_EXPOSE;
            cnt    <= '0;
            ERASE  <= 1'b0;
            EXPOSE <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_EXPOSE: begin
          if (cnt == CNT_W'(exp_last)) begin
            state   <= S_CONVERT;
            cnt     <= '0;
            EXPOSE  <= 1'b0;
            CONVERT <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CONVERT: begin
          // RAMP is high on odd counter values; it is set from the next count.
          if (cnt == CONV_LAST) begin
            state   <= S_READ;
            cnt     <= '0;
            CONVERT <= 1'b0;
            READ    <= 1'b1;
          end else begin
            cnt  <= cnt + CNT_W'(1);
            RAMP <= ~cnt[0];
          end
        end
        S_READ: begin
          if (cnt == READ_LAST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            READ       <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          ERASE   <= 1'b0;
          EXPOSE  <= 1'b0;
          CONVERT <= 1'b0;
          READ    <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: a frame-schedule model predicts every output each
// cycle; directed and randomized frames add literal checks on frame shape.
module tb_pixel_array_ctrl;
  localparam int EC = 4;
  localparam int RS = 255;
  localparam int RC = 2;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] exp_time = '0;
  logic erase, expose, convert, ramp, read, array_reset, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pixel_array_ctrl #(
    .ERASE_CYCLES(EC),
    .RAMP_STEPS  (RS),
    .READ_CYCLES (RC),
    .EXP_W       (EW)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .START      (start),
    .EXP_TIME   (exp_time),
    .ERASE      (erase),
    .EXPOSE     (expose),
    .CONVERT    (convert),
    .RAMP       (ramp),
    .READ       (read),
    .ARRAY_RESET(array_reset),
    .BUSY       (busy),
    .FRAME_DONE (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a frame is a span of L cycles indexed by offset from its first ERASE cycle.
  bit m_valid = 0, m_in = 0, m_done = 0, m_hold = 1;
  int m_off = 0, m_e = 1;

  always @(posedge clk) begin
    m_valid = 1;
    if (!rst_n) begin
      m_in = 0; m_done = 0; m_hold = 1;
    end else begin
      m_hold = 0;
      if (m_in) begin
        m_off++;
        if (m_off == EC + m_e + 2 * RS + 1 + RC) begin
          m_in = 0; m_done = 1;
        end
      end else begin
        m_done = 0;
        if (start) begin
          m_in = 1; m_off = 0;
          m_e = (exp_time == 0) ? 1 : int'(exp_time);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int ce, cc, c;
    if (m_valid) begin
      ce = EC + m_e;
      cc = ce + 2 * RS + 1;
      c  = m_off - ce;
      check("ERASE",   erase,   m_in && m_off < EC);
      check("EXPOSE",  expose,  m_in && m_off >= EC && m_off < ce);
      check("CONVERT", convert, m_in && m_off >= ce && m_off < cc);
      check("RAMP",    ramp,    m_in && m_off >= ce && m_off < cc && (c % 2 == 1));
      check("READ",    read,    m_in && m_off >= cc);
      check("ARRAY_RESET", array_reset, m_hold || (m_in && m_off == 0));
      check("BUSY",       busy,       m_in);
      check("FRAME_DONE", frame_done, m_done);
      check("exclusive", $countones({erase, expose, convert, read}) <= 1, 1);
      check("ramp_wo_convert", ramp && !convert, 0);
    end
  end

  // Frame statistics measured from the DUT pins, for literal shape checks.
  int run_len = 0, run_erase = 0, run_expose = 0, run_conv = 0, run_read = 0;
  int run_rr = 0, run_rdr = 0, run_arst = 0;
  int last_len = 0, last_erase = 0, last_expose = 0, last_conv = 0, last_read = 0;
  int last_rr = 0, last_rdr = 0, last_arst = 0;
  int idle_run = 0, last_gap = 0, done_cnt = 0;
  bit prev_busy = 0, prev_ramp = 0, prev_read = 0;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!prev_busy) begin last_gap = idle_run; idle_run = 0; end
      run_len++;
      run_erase  += int'(erase === 1'b1);
      run_expose += int'(expose === 1'b1);
      run_conv   += int'(convert === 1'b1);
      run_read   += int'(read === 1'b1);
      run_arst   += int'(array_reset === 1'b1);
      if (ramp === 1'b1 && !prev_ramp) run_rr++;
      if (read === 1'b1 && !prev_read) run_rdr++;
    end else begin
      if (prev_busy) begin
        last_len = run_len; last_erase = run_erase; last_expose = run_expose;
        last_conv = run_conv; last_read = run_read; last_rr = run_rr;
        last_rdr = run_rdr; last_arst = run_arst;
        run_len = 0; run_erase = 0; run_expose = 0; run_conv = 0;
        run_read = 0; run_rr = 0; run_rdr = 0; run_arst = 0;
      end
      idle_run++;
    end
    if (frame_done === 1'b1) done_cnt++;
    prev_busy = (busy === 1'b1);
    prev_ramp = (ramp === 1'b1);
    prev_read = (read === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [EW-1:0] e);
    @(negedge clk);
    exp_time = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_in_time"}, k < budget, 1);
    #1;
  endtask

  task automatic check_frame(input string name, input int len, input int e);
    check({name, "_len"},       last_len,    len);
    check({name, "_erase"},     last_erase,  EC);
    check({name, "_expose"},    last_expose, e);
    check({name, "_convert"},   last_conv,   2 * RS + 1);
    check({name, "_read"},      last_read,   RC);
    check({name, "_ramp_rise"}, last_rr,     RS);
    check({name, "_read_rise"}, last_rdr,    1);
    check({name, "_arst"},      last_arst,   1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, r, cv, t;
    exp_time = 8'd10;
    repeat (3) @(negedge clk);
    check("rst_arst", array_reset, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_arst", array_reset, 0);
    cycles(20);
    check("idle_busy", busy, 0);
    check("idle_done_cnt", done_cnt, 0);

    // Default frame, EXP_TIME=10
    dc = done_cnt;
    pulse_start(8'd10);
    check("start_erase", erase, 1);
    check("start_arst", array_reset, 1);
    check("start_busy", busy, 1);
    wait_done("f10", 2000);
    check_frame("f10", 527, 10);
    cycles(5);
    check("f10_one_done", done_cnt, dc + 1);

    // Zero exposure behaves as one cycle
    pulse_start(8'd0);
    wait_done("f0", 2000);
    check_frame("f0", 518, 1);

    // START held high: back-to-back frames, mid-frame EXP_TIME changes deferred
    exp_time = 8'd3;
    start = 1'b1;
    cycles(100);
    r = $urandom_range(20, 60);
    exp_time = 8'(r);
    wait_done("h1", 2000);
    check_frame("h1", 520, 3);
    cycles(100);
    exp_time = 8'd3;
    wait_done("h2", 2000);
    check_frame("h2", EC + r + 2 * RS + 1 + RC, r);
    check("h2_gap", last_gap, 1);
    wait_done("h3", 2000);
    start = 1'b0;
    check_frame("h3", 520, 3);
    check("h3_gap", last_gap, 1);
    cycles(3);
    check("h_stop_busy", busy, 0);

    // Reset at CONVERT cycle 100
    dc = done_cnt;
    pulse_start(8'd10);
    cv = 0; t = 0;
    while (cv < 101 && t < 1000) begin
      if (convert === 1'b1) cv++;
      if (cv < 101) begin @(negedge clk); t++; end
    end
    check("abort_reach_conv100", cv, 101);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_convert", convert, 0);
    check("abort_ramp", ramp, 0);
    check("abort_busy", busy, 0);
    check("abort_arst1", array_reset, 1);
    @(negedge clk);
    check("abort_arst2", array_reset, 1);
    @(negedge clk);
    check("abort_arst3", array_reset, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_arst_rel", array_reset, 0);
    cycles(10);
    check("abort_no_done", done_cnt, dc);
    pulse_start(8'd10);
    wait_done("after_abort", 2000);
    check_frame("after_abort", 527, 10);

    // Randomized frames, mid-frame EXP_TIME noise and occasional resets
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 40);
      cycles($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        pulse_start(8'(r));
        cycles($urandom_range(1, 500));
        rst_n = 1'b0;
        cycles($urandom_range(1, 3));
        rst_n = 1'b1;
        cycles(2);
      end else begin
        pulse_start(8'(r));
        cycles($urandom_range(1, 30));
        exp_time = 8'($urandom);
        wait_done("rnd", 2000);
        check_frame("rnd", EC + ((r == 0) ? 1 : r) + 2 * RS + 1 + RC, (r == 0) ? 1 : r);
      end
    end
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Frame sequencer that drives the control pins of the pixel array: it generates ERASE, EXPOSE, CONVERT, READ, the ADC ramp clock RAMP and the array reset pulse, so that one START request produces one complete erase/expose/convert/read frame. It sits directly upstream of the pixel array, and all its outputs connect 1:1 to the array's same-named control inputs (ARRAY_RESET drives the array's RESET). Exposure time is programmable per frame.

## Interface
Parameters:
- ERASE_CYCLES, 4: clock cycles ERASE is held high (≥1).
- RAMP_STEPS, 255: RAMP rising edges per conversion (≥1); sets the ADC code range.
- READ_CYCLES, 2: clock cycles READ is held high (≥1).
- EXP_W, 8: width of EXP_TIME.

Ports:
- CLK  in  1  single clock. All state changes on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  frame request, level-sensitive, sampled only in IDLE.
- EXP_TIME  in  EXP_W  exposure length in cycles, captured when START is accepted. 0 is treated as 1.
- ERASE  out  1  array erase.
- EXPOSE  out  1  array expose.
- CONVERT  out  1  array convert enable.
- RAMP  out  1  ramp/counter clock to the array.
- READ  out  1  array read; its rising edge latches DATA1..4.
- ARRAY_RESET  out  1  array reset (active high).
- BUSY  out  1  high whenever state ≠ IDLE.
- FRAME_DONE  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ. Encoding is free. All outputs are registered and decoded from the state plus a shared phase counter.
- IDLE: all control outputs low. When START=1, capture EXP_TIME (0→1), clear the counter and go to ERASE.
- ERASE: ERASE=1 for ERASE_CYCLES cycles. ARRAY_RESET=1 in the first ERASE cycle only, which clears the array's output registers and counter. Then go to EXPOSE.
- EXPOSE: EXPOSE=1 for the captured exposure count in cycles. Then go to CONVERT.
- CONVERT: CONVERT=1 for exactly 2·RAMP_STEPS+1 cycles. The counter c runs 0..2·RAMP_STEPS, and RAMP=1 when c is odd. This gives exactly RAMP_STEPS rising edges, each while CONVERT=1. RAMP is low in the first and last CONVERT cycles and low in every other state. Then go to READ.
- READ: READ=1 for READ_CYCLES cycles, with one rising edge per frame. Then go to IDLE and pulse FRAME_DONE.
- Control outputs ERASE, EXPOSE, CONVERT and READ are mutually exclusive (at most one high), with no gap cycles between phases.
- The phase counter is wide enough for max(ERASE_CYCLES, 2^EXP_W−1, 2·RAMP_STEPS+1, READ_CYCLES). It never wraps within a phase.
- START and EXP_TIME are ignored while BUSY. Changes to EXP_TIME mid-frame do not affect the current frame.
- START held high: frames run back-to-back. The next ERASE begins the cycle after the FRAME_DONE cycle.
- Reset (RESET_N=0 at a clock edge), from any state including mid-CONVERT:
  - next cycle: state IDLE, all outputs 0 except ARRAY_RESET=1;
  - ARRAY_RESET stays 1 for every cycle RESET_N is low and drops in the first cycle after release;
  - no FRAME_DONE is produced for an aborted frame.

## Timing
- Reset values: ERASE=EXPOSE=CONVERT=READ=RAMP=BUSY=FRAME_DONE=0, ARRAY_RESET=1.
- Start latency: START sampled high at edge t gives ERASE=1, ARRAY_RESET=1 and BUSY=1 from edge t+1.
- Frame length (BUSY high): ERASE_CYCLES + E + 2·RAMP_STEPS+1 + READ_CYCLES cycles, where E = max(EXP_TIME, 1).
- FRAME_DONE: high in the single IDLE cycle following the last READ cycle, with BUSY=0 in that same cycle.
- Each output transitions only at rising CLK edges and is glitch-free.

## Test plan
- Reset release, START=0 -> all outputs 0 except ARRAY_RESET, which is 1 during reset and 0 one cycle after release. Outputs stay idle for 20 cycles.
- Defaults, EXP_TIME=10, single START pulse -> ERASE 4 cycles (ARRAY_RESET only in the first), EXPOSE 10, CONVERT 511 with exactly 255 RAMP rising edges, READ 2. BUSY high for 527 cycles, then one FRAME_DONE.
- EXP_TIME=0 -> EXPOSE high exactly 1 cycle; frame length 518.
- START held high, EXP_TIME=3 -> consecutive frames of 520 cycles, each separated by exactly one IDLE/FRAME_DONE cycle. EXP_TIME changed mid-frame takes effect only in the next frame.
- RESET_N low for 3 cycles at CONVERT cycle 100 -> outputs idle next cycle, ARRAY_RESET high 3 cycles, no FRAME_DONE. A new START then yields a full 527-cycle frame.
- Throughout all scenarios (checker assertion) -> at most one of ERASE/EXPOSE/CONVERT/READ high at any time, and RAMP never high unless CONVERT=1.
